// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: the WB stage always wins, late mult/div results
// wait in a small FIFO and drain in WB-idle cycles, with a starvation-driven stall request.
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_RegWr,
  input  logic [4:0]               wb_addr,
  input  logic [31:0]              wb_data,
  input  logic                     md_valid,
  input  logic [4:0]               md_addr,
  input  logic [31:0]              md_data,
  output logic                     md_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_addr,
  output logic [31:0]              rf_data,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   pend_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW:0]   CNT_DEPTH = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [SW-1:0] LIMIT     = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STV_ONE   = SW'(1);

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_data_q, rf_data_d;

  logic wb_active;
  logic fifo_empty;
  logic head_vld;
  logic pop_vld;
  logic pop_sq;
  logic pop;
  logic enq;

  assign wb_active  = wb_RegWr && (wb_addr != 5'd0);
  assign fifo_empty = (cnt_q == '0);
  assign head_vld   = !fifo_empty && vld_q[rd_ptr_q];
  assign pop_vld    = head_vld && !wb_active;
  // A squashed head carries no write, so it can leave even while WB owns the port.
  assign pop_sq     = !fifo_empty && !vld_q[rd_ptr_q];
  assign pop        = pop_vld || pop_sq;
  assign md_ready   = (cnt_q < CNT_DEPTH);
  assign enq        = md_valid && md_ready && (md_addr != 5'd0);

  always_comb begin
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    // Queued results are older than the WB instruction; its write supersedes them.
    if (wb_active) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == wb_addr) vld_d[i] = 1'b0;
      end
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_ONE;
    end
    if (enq) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    case ({enq, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (pop_vld || fifo_empty) begin
      starve_d = '0;
    end else if (head_vld && (starve_q != LIMIT)) begin
      starve_d = starve_q + STV_ONE;
    end
    // Once raised, the stall holds until nothing valid remains to drain.
    if (stall_q) begin
      stall_d = |vld_d;
    end else begin
      stall_d = (starve_d == LIMIT);
    end
  end

  always_comb begin
    rf_we_d   = wb_active || pop_vld;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (wb_active) begin
      rf_addr_d = wb_addr;
      rf_data_d = wb_data;
    end else if (pop_vld) begin
      rf_addr_d = addr_q[rd_ptr_q];
      rf_data_d = data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      vld_q     <= vld_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= md_addr;
      data_q[wr_ptr_q] <= md_data;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;
  assign stall_req  = stall_q;
  assign pend_count = cnt_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: a queue-based reference model predicts
// every register-file write and the per-cycle status outputs.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_RegWr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        stall_req;
  logic [$clog2(DEPTH):0] pend_count;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .wb_RegWr(wb_RegWr), .wb_addr(wb_addr), .wb_data(wb_data),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .stall_req(stall_req), .pend_count(pend_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; bit v; } ent_t;
  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { bit we; logic [4:0] a; logic [31:0] d; int pend; bit rdy; bit stall; } st_t;

  ent_t mq[$];
  wr_t  wq[$];
  st_t  sq[$];
  bit          m_we;
  logic [4:0]  m_a;
  logic [31:0] m_d;
  int          m_starve;
  bit          m_stall;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete(); wq.delete(); sq.delete();
    m_we = 0; m_a = '0; m_d = '0; m_starve = 0; m_stall = 0;
  endfunction

  // One clock of the arbiter described in terms of a list of pending results.
  function automatic void model_step(bit we, logic [4:0] wa, logic [31:0] wd,
                                     bit mv, logic [4:0] ma, logic [31:0] md);
    bit act = we && (wa != 0);
    int n0 = mq.size();
    bit hv = (n0 > 0) && mq[0].v;
    bit rdy = (n0 < DEPTH);
    bit popped_v = 0;
    bit any = 0;
    ent_t e;
    m_we = 0;
    if (act) begin
      m_we = 1; m_a = wa; m_d = wd;
      wq.push_back('{wa, wd});
    end else if (hv) begin
      e = mq.pop_front();
      m_we = 1; m_a = e.a; m_d = e.d;
      wq.push_back('{e.a, e.d});
      popped_v = 1;
    end
    if (!popped_v && n0 > 0 && !mq[0].v) e = mq.pop_front();
    if (act) foreach (mq[i]) if (mq[i].a == wa) mq[i].v = 0;
    if (mv && rdy && ma != 0) mq.push_back('{ma, md, 1'b1});
    if (popped_v || n0 == 0) m_starve = 0;
    else if (hv && m_starve < LIM) m_starve++;
    if (m_stall) begin
      foreach (mq[i]) any |= mq[i].v;
      m_stall = any;
    end else begin
      m_stall = (m_starve == LIM);
    end
  endfunction

  task automatic step(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md);
    @(posedge clk); #1;
    sq.push_back('{m_we, m_a, m_d, mq.size(), (mq.size() < DEPTH), m_stall});
    wb_RegWr = we; wb_addr = wa; wb_data = wd;
    md_valid = mv; md_addr = ma; md_data = md;
    model_step(we, wa, wd, mv, ma, md);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 0;
    wb_RegWr = 0; wb_addr = '0; wb_data = '0;
    md_valid = 0; md_addr = '0; md_data = '0;
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'h0);
    chk("rst_rf_addr", 32'(rf_addr), 32'h0);
    chk("rst_rf_data", rf_data, 32'h0);
    chk("rst_stall", 32'(stall_req), 32'h0);
    chk("rst_pend", 32'(pend_count), 32'h0);
    chk("rst_md_ready", 32'(md_ready), 32'h1);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  // Monitor: status every cycle, write scoreboard whenever rf_we is presented.
  initial begin
    st_t e;
    wr_t w;
    forever begin
      @(negedge clk);
      if (reset && sq.size() > 0) begin
        e = sq.pop_front();
        chk("rf_we", 32'(rf_we), 32'(e.we));
        chk("rf_addr_hold", 32'(rf_addr), 32'(e.a));
        chk("rf_data_hold", rf_data, e.d);
        chk("pend_count", 32'(pend_count), 32'(e.pend));
        chk("md_ready", 32'(md_ready), 32'(e.rdy));
        chk("stall_req", 32'(stall_req), 32'(e.stall));
      end
      if (reset && rf_we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_write: got addr %0d data 0x%0h expected no write", rf_addr, rf_data);
        end else begin
          w = wq.pop_front();
          chk("sb_addr", 32'(rf_addr), 32'(w.a));
          chk("sb_data", rf_data, w.d);
        end
      end
    end
  end

  initial begin
    int p;
    reset = 1;
    wb_RegWr = 0; wb_addr = '0; wb_data = '0;
    md_valid = 0; md_addr = '0; md_data = '0;
    model_reset();
    #2 reset = 0;
    #1;
    chk("init_rf_we", 32'(rf_we), 32'h0);
    chk("init_pend", 32'(pend_count), 32'h0);
    chk("init_md_ready", 32'(md_ready), 32'h1);
    repeat (2) @(posedge clk);
    #1 reset = 1;

    // Back-to-back WB writes.
    step(1, 5'd5, 32'h11, 0, 0, 0);
    step(1, 5'd6, 32'h22, 0, 0, 0);
    idle(2);
    // Enqueue under WB, drained by one idle cycle.
    step(1, 5'd1, 32'h1, 1, 5'd9, 32'hABCD);
    idle(3);
    // Fill under continuous WB, starve into stall, then drain in order.
    for (int i = 0; i < 14; i++)
      step(1, 5'd1, 32'(i), (i < 5), 5'(10 + i), 32'h100 + 32'(i));
    idle(6);
    // Squash of an older queued result.
    step(1, 5'd1, 32'h2, 1, 5'd7, 32'h1);
    step(1, 5'd1, 32'h3, 1, 5'd8, 32'h2);
    step(1, 5'd7, 32'h55, 0, 0, 0);
    idle(3);
    // Same-cycle WB and enqueue to the same register: no squash.
    step(1, 5'd3, 32'h10, 1, 5'd3, 32'h20);
    idle(3);
    // Zero destination: WB-idle and discarded enqueue.
    step(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
    idle(2);
    // Reset with pending entries and an active stall.
    for (int i = 0; i < 12; i++)
      step(1, 5'd2, 32'(i), (i < 3), 5'(20 + i), 32'h200 + 32'(i));
    do_reset();
    idle(4);

    // Randomized traffic with phases of varying WB pressure.
    for (int blk = 0; blk < 20; blk++) begin
      p = (blk % 3 == 0) ? 30 : ((blk % 3 == 1) ? 85 : 100);
      for (int i = 0; i < 40; i++)
        step(($urandom_range(0, 99) < p), 5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
      if (blk == 10) do_reset();
    end
    idle(20);
    @(negedge clk); #1;
    chk("drain_sb_empty", 32'(wq.size()), 32'h0);
    chk("drain_pend", 32'(pend_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters.
  - The pipeline write-back stage is fed by the MEM-to-WB register outputs (write enable, destination, selected write data).
  - The multi-cycle multiply/divide unit delivers results late.
- WB always wins.
- Late results wait in a small FIFO and drain in WB idle cycles.
- A starvation guard requests a front-end stall so that the guard can open idle WB slots.

Parameters:
- DEPTH, 4, pending-result FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 8, consecutive non-draining cycles with FIFO non-empty before stall_req asserts.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_RegWr  in  1  WB-stage write request.
- wb_addr  in  5  WB-stage destination register.
- wb_data  in  32  WB-stage write data (already muxed).
- md_valid  in  1  mult/div result offered.
- md_addr  in  5  mult/div destination register.
- md_data  in  32  mult/div result.
- md_ready  out  1  FIFO can accept; a transfer happens when md_valid and md_ready are both high.
- rf_we  out  1  register-file write enable.
- rf_addr  out  5  register-file write address.
- rf_data  out  32  register-file write data.
- stall_req  out  1  request to the hazard unit to freeze IF/ID and inject bubbles.
- pend_count  out  log2(DEPTH)+1  number of FIFO entries, valid or squashed.

Behaviour:
- Reset (asynchronous, while reset=0): rf_we=0, rf_addr=0, rf_data=0, stall_req=0, pend_count=0, FIFO empty, all valid bits 0, starvation counter 0.
  - md_ready=1 is derived from the empty FIFO.
- Reset mid-operation discards all pending entries without writing them.
- WB-active cycle: wb_RegWr=1 and wb_addr!=0. Any other WB cycle is WB-idle.
  - wb_RegWr=1 with wb_addr=0 is WB-idle.
- rf_* outputs are registered, with 1-cycle latency.
  - The winner in cycle N is presented on rf_* in cycle N+1 for exactly one cycle.
  - rf_we=0 in N+1 if there is no winner.
  - rf_addr and rf_data hold their last values when rf_we=0.
- Arbitration each cycle, in priority order:
  1. WB-active: WB wins, and the FIFO does not pop a valid head.
  2. WB-idle and FIFO head valid: the head wins and is popped.
  3. A squashed (invalid) head is popped in any cycle, with no write. Only one pop per cycle.
- Squash rule: entries already in the FIFO are older in program order than the current WB instruction.
  - On a WB-active cycle, every FIFO entry with addr == wb_addr has its valid bit cleared in that cycle.
  - A same-cycle enqueue with the same addr is not squashed; it is newer.
- Enqueue:
  - md_ready = (pend_count < DEPTH), computed from registered state only.
  - An enqueue and a pop in the same cycle while full is not allowed; md_ready is already 0 in that case.
  - md_addr=0 transfers are accepted and discarded; no entry is created.
  - Enqueue and pop in the same cycle: pend_count is unchanged.
- FIFO order is strict: head is oldest. Read/write pointers wrap modulo DEPTH.
- Starvation counter:
  - Increments each cycle the FIFO holds a valid head but the head is not popped. Saturates at STARVE_LIMIT.
  - Clears on any pop of a valid head, or when the FIFO is empty.
- stall_req:
  - Registered, set when the counter reaches STARVE_LIMIT.
  - Stays 1 until the FIFO contains no valid entries, then clears on the next edge.
- Empty boundary: no pop, rf_we reflects WB only, stall_req=0.

Test Plan:
- Release reset, then drive WB writes r5=0x11 and r6=0x22 back-to-back → rf_we=1 on the next two cycles with matching addr/data, and md_ready stays 1.
- Enqueue md r9=0xABCD while WB is active, then one WB-idle cycle → that idle cycle pops the entry; rf_we=1, rf_addr=9, rf_data=0xABCD on the following cycle.
- Fill all 4 entries with WB continuously active → md_ready=0 and pend_count=4. stall_req=1 exactly STARVE_LIMIT=8 non-draining cycles after the first enqueue. Then drive 4 idle WB cycles → 4 writes in FIFO order, and stall_req drops one cycle after the last valid pop.
- Enqueue r7=1 and r8=2, then WB writes r7=0x55 → the r7 entry is squashed. Two WB-idle cycles produce only the r8 write; pend_count reaches 0.
- Same-cycle WB r3=0x10 and md enqueue r3=0x20, followed by one idle cycle → r3=0x10 is written first and r3=0x20 one cycle later; no squash occurs.
- Assert reset with 3 pending entries and stall_req=1 → all outputs reach their reset values immediately with no clock edge, and no pending write appears after reset is released.
